// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//
// Purpose:
//   Moore-style instruction sequencer for a simple datapath. An instruction is
//   accepted in WAIT when s is high. Its opcode/op fields are captured at that
//   edge and steer the whole sequence. Later changes on the opcode/op inputs
//   are ignored until the next acceptance. Every output is decoded from the
//   state register and the captured instruction fields only. There is no
//   combinational path from any input to any output.
//
// Ports:
//   clk     in   datapath clock, rising-edge active
//   reset   in   asynchronous active-high reset, forces WAIT
//   s       in   start request, sampled only in WAIT
//   opcode  in   [2:0] instruction bits [15:13]
//   op      in   [1:0] instruction bits [12:11]
//   w       out  high only in WAIT (idle, ready for s)
//   nsel    out  [2:0] one-hot register select: 001=Rm, 010=Rd, 100=Rn
//   vsel    out  [1:0] writeback source: 00=C, 10=sximm8
//   loada   out  A register load enable
//   loadb   out  B register load enable
//   loadc   out  C register load enable
//   loads   out  status register load enable
//   asel    out  1 selects zero for the ALU A input
//   bsel    out  1 selects sximm5 for the ALU B input
//   write   out  register file write enable
// -----------------------------------------------------------------------------
module cpu_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU_OP    = 3'd5,
        S_CMP_OP    = 3'd6,
        S_WRITE_REG = 3'd7
    } state_t;

    // Combined {opcode, op} codes of the supported instructions.
    localparam logic [4:0] INSN_MOV_IMM = 5'b110_10;
    localparam logic [4:0] INSN_MOV_REG = 5'b110_00;
    localparam logic [4:0] INSN_MVN     = 5'b101_11;
    localparam logic [4:0] INSN_ADD     = 5'b101_00;
    localparam logic [4:0] INSN_CMP     = 5'b101_01;
    localparam logic [4:0] INSN_AND     = 5'b101_10;

    state_t     state_q, state_d;
    logic [2:0] opcode_q, opcode_d;
    logic [1:0] op_q, op_d;
    logic [4:0] insn_s;

    assign insn_s = {opcode_q, op_q};

    // State and captured instruction fields; reset returns to an idle, cleared controller.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_WAIT;
            opcode_q <= 3'b000;
            op_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op_q     <= op_d;
        end
    end

    // Next-state logic and instruction capture.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        op_d     = op_q;
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    state_d  = S_DECODE;
                    opcode_d = opcode;
                    op_d     = op;
                end else begin
                    state_d  = S_WAIT;
                end
            end
            S_DECODE: begin
                // Unsupported encodings drop straight back to WAIT with no side effects.
                if (insn_s == INSN_MOV_IMM) begin
                    state_d = S_WRITE_IMM;
                end else if ((insn_s == INSN_MOV_REG) || (insn_s == INSN_MVN)) begin
                    state_d = S_GET_B;
                end else if ((insn_s == INSN_ADD) || (insn_s == INSN_CMP) ||
                             (insn_s == INSN_AND)) begin
                    state_d = S_GET_A;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B: begin
                if (insn_s == INSN_CMP) begin
                    state_d = S_CMP_OP;
                end else begin
                    state_d = S_ALU_OP;
                end
            end
            S_ALU_OP:    state_d = S_WRITE_REG;
            S_CMP_OP:    state_d = S_WAIT;
            S_WRITE_REG: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Moore output decode from the state register and the captured fields.
    always_comb begin
        w     = 1'b0;
        nsel  = 3'b000;
        vsel  = 2'b00;
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        write = 1'b0;
        case (state_q)
            S_WAIT: w = 1'b1;
            S_DECODE: begin
                w = 1'b0;
            end
            S_WRITE_IMM: begin
                nsel  = 3'b100;
                vsel  = 2'b10;
                write = 1'b1;
            end
            S_GET_A: begin
                nsel  = 3'b100;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = 3'b001;
                loadb = 1'b1;
            end
            S_ALU_OP: begin
                loadc = 1'b1;
                // MOV reg and MVN pass B through, so A is forced to zero.
                if ((insn_s == INSN_MOV_REG) || (insn_s == INSN_MVN)) begin
                    asel = 1'b1;
                end else begin
                    asel = 1'b0;
                end
            end
            S_CMP_OP: begin
                loads = 1'b1;
            end
            S_WRITE_REG: begin
                nsel  = 3'b010;
                vsel  = 2'b00;
                write = 1'b1;
            end
            default: begin
                w = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
//
// Directed bench for cpu_controller. Expected output vectors are pushed to a
// scoreboard queue as each step is driven. They are popped and compared once
// the DUT has settled after the edge, or after an asynchronous reset.
// Output vector layout:
//   {w, nsel[2:0], vsel[1:0], loada, loadb, loadc, loads, asel, bsel, write}
// -----------------------------------------------------------------------------
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada, loadb, loadc, loads, asel, bsel, write;

    logic [12:0] obs_s;
    logic [12:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;

    localparam logic [12:0] E_WAIT    = {1'b1, 3'b000, 2'b00, 7'b0000000};
    localparam logic [12:0] E_DEC     = {1'b0, 3'b000, 2'b00, 7'b0000000};
    localparam logic [12:0] E_WIMM    = {1'b0, 3'b100, 2'b10, 7'b0000001};
    localparam logic [12:0] E_GETA    = {1'b0, 3'b100, 2'b00, 7'b1000000};
    localparam logic [12:0] E_GETB    = {1'b0, 3'b001, 2'b00, 7'b0100000};
    localparam logic [12:0] E_ALU_ADD = {1'b0, 3'b000, 2'b00, 7'b0010000};
    localparam logic [12:0] E_ALU_MOV = {1'b0, 3'b000, 2'b00, 7'b0010100};
    localparam logic [12:0] E_CMP     = {1'b0, 3'b000, 2'b00, 7'b0001000};
    localparam logic [12:0] E_WREG    = {1'b0, 3'b010, 2'b00, 7'b0000001};

    cpu_controller dut (
        .clk    (clk),
        .reset  (reset),
        .s      (s),
        .opcode (opcode),
        .op     (op),
        .w      (w),
        .nsel   (nsel),
        .vsel   (vsel),
        .loada  (loada),
        .loadb  (loadb),
        .loadc  (loadc),
        .loads  (loads),
        .asel   (asel),
        .bsel   (bsel),
        .write  (write)
    );

    always #5 clk = ~clk;

    assign obs_s = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write};

    task automatic compare(input string tag);
        logic [12:0] e;
        e = sb_q.pop_front();
        checks++;
        assert (obs_s === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs_s, e);
        end
    endtask

    // Expect e after the next rising edge (sampled 1 time unit later).
    task automatic edge_expect(input string tag, input logic [12:0] e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    // Expect e without any clock edge (asynchronous behaviour).
    task automatic now_expect(input string tag, input logic [12:0] e);
        sb_q.push_back(e);
        #1;
        compare(tag);
    endtask

    task automatic start(input logic [2:0] opc, input logic [1:0] o);
        s      = 1'b1;
        opcode = opc;
        op     = o;
    endtask

    // Drop s and scramble the instruction inputs; the latched copy must rule.
    task automatic drop_s();
        s      = 1'b0;
        opcode = 3'b111;
        op     = 2'b11;
    endtask

    initial begin
        reset  = 1'b1;
        s      = 1'b0;
        opcode = 3'b000;
        op     = 2'b00;
        #2;
        now_expect("reset_state", E_WAIT);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // MOV immediate: 3 edges to w=1.
        start(3'b110, 2'b10);
        edge_expect("movi_decode", E_DEC);
        drop_s();
        edge_expect("movi_write", E_WIMM);
        edge_expect("movi_wait", E_WAIT);
        edge_expect("idle_s0", E_WAIT);

        // ADD: 6 edges.
        start(3'b101, 2'b00);
        edge_expect("add_decode", E_DEC);
        drop_s();
        edge_expect("add_geta", E_GETA);
        edge_expect("add_getb", E_GETB);
        edge_expect("add_alu", E_ALU_ADD);
        edge_expect("add_wreg", E_WREG);
        edge_expect("add_wait", E_WAIT);

        // CMP: 5 edges, no write.
        start(3'b101, 2'b01);
        edge_expect("cmp_decode", E_DEC);
        drop_s();
        edge_expect("cmp_geta", E_GETA);
        edge_expect("cmp_getb", E_GETB);
        edge_expect("cmp_loads", E_CMP);
        edge_expect("cmp_wait", E_WAIT);

        // MOV reg, opcode changed to 111 during DECODE.
        start(3'b110, 2'b00);
        edge_expect("movr_decode", E_DEC);
        s      = 1'b0;
        opcode = 3'b111;
        op     = 2'b00;
        edge_expect("movr_getb", E_GETB);
        edge_expect("movr_alu", E_ALU_MOV);
        edge_expect("movr_wreg", E_WREG);
        edge_expect("movr_wait", E_WAIT);

        // MVN.
        start(3'b101, 2'b11);
        edge_expect("mvn_decode", E_DEC);
        drop_s();
        edge_expect("mvn_getb", E_GETB);
        edge_expect("mvn_alu", E_ALU_MOV);
        edge_expect("mvn_wreg", E_WREG);
        edge_expect("mvn_wait", E_WAIT);

        // AND.
        start(3'b101, 2'b10);
        edge_expect("and_decode", E_DEC);
        drop_s();
        edge_expect("and_geta", E_GETA);
        edge_expect("and_getb", E_GETB);
        edge_expect("and_alu", E_ALU_ADD);
        edge_expect("and_wreg", E_WREG);
        edge_expect("and_wait", E_WAIT);

        // ADD aborted by reset during GET_B.
        start(3'b101, 2'b00);
        edge_expect("abort_decode", E_DEC);
        drop_s();
        edge_expect("abort_geta", E_GETA);
        edge_expect("abort_getb", E_GETB);
        reset = 1'b1;
        now_expect("abort_async_wait", E_WAIT);
        start(3'b110, 2'b10);
        edge_expect("abort_held", E_WAIT);
        reset = 1'b0;
        // First edge after release with s=1 accepts normally.
        edge_expect("post_reset_decode", E_DEC);
        drop_s();
        edge_expect("post_reset_wimm", E_WIMM);
        edge_expect("post_reset_wait", E_WAIT);

        // Illegal encodings: DECODE then WAIT, no enables.
        start(3'b111, 2'b00);
        edge_expect("ill111_decode", E_DEC);
        drop_s();
        edge_expect("ill111_wait", E_WAIT);
        start(3'b110, 2'b01);
        edge_expect("ill110_decode", E_DEC);
        drop_s();
        edge_expect("ill110_wait", E_WAIT);
        start(3'b100, 2'b10);
        edge_expect("ill100_decode", E_DEC);
        drop_s();
        edge_expect("ill100_wait", E_WAIT);

        // Back-to-back MOV immediate with s held high.
        start(3'b110, 2'b10);
        edge_expect("b2b_decode1", E_DEC);
        edge_expect("b2b_wimm1", E_WIMM);
        edge_expect("b2b_wait", E_WAIT);
        edge_expect("b2b_decode2", E_DEC);
        drop_s();
        edge_expect("b2b_wimm2", E_WIMM);
        edge_expect("b2b_wait2", E_WAIT);
        edge_expect("b2b_idle", E_WAIT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
